// File: rtl/ex_muldiv_if.sv
// Operand/result bundle between the execute stage and the iterative multiply-divide unit.
// The master side is the pipeline; the slave side is ex_muldiv.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            cancel;
  logic [2:0]      op;
  logic [XLEN-1:0] s1data;
  logic [XLEN-1:0] s2data;
  logic [4:0]      rd;
  logic            regwe;
  logic            stallreq;
  logic            busy;
  logic            valid;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_o;
  logic            regwe_o;

  modport master (
    output start, cancel, op, s1data, s2data, rd, regwe,
    input  stallreq, busy, valid, result, rd_o, regwe_o
  );

  modport slave (
    input  start, cancel, op, s1data, s2data, rd, regwe,
    output stallreq, busy, valid, result, rd_o, regwe_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M/RV64M multiply-divide unit: one bit per cycle through a shared
// 2*XLEN accumulator, with early-out for divide-by-zero and signed overflow.
module ex_muldiv #(
  parameter int XLEN = 32,
  parameter int CNTW = $clog2(XLEN + 1)
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  mdu
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              regwe_lat_q, regwe_lat_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_o_q, rd_o_d;
  logic              regwe_o_q, regwe_o_d;

  // Operand decode for the accept cycle
  logic            s1_signed, s2_signed, s1_neg, s2_neg;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_zero, div_ovf, early_out;
  logic [XLEN-1:0] early_res;
  logic            accept;

  always_comb begin
    s1_signed = (mdu.op == 3'd1) || (mdu.op == 3'd2) || (mdu.op == 3'd4) || (mdu.op == 3'd6);
    s2_signed = (mdu.op == 3'd1) || (mdu.op == 3'd4) || (mdu.op == 3'd6);
    s1_neg    = s1_signed & mdu.s1data[XLEN-1];
    s2_neg    = s2_signed & mdu.s2data[XLEN-1];
    mag1      = s1_neg ? -mdu.s1data : mdu.s1data;
    mag2      = s2_neg ? -mdu.s2data : mdu.s2data;
    div_zero  = mdu.op[2] & (mdu.s2data == '0);
    div_ovf   = mdu.op[2] & ~mdu.op[0] & (mdu.s1data == MIN_VAL) & (mdu.s2data == '1);
    early_out = div_zero | div_ovf;
    if (div_zero) begin
      early_res = mdu.op[1] ? mdu.s1data : '1;
    end else begin
      early_res = mdu.op[1] ? '0 : MIN_VAL;
    end
    accept = (state_q == IDLE) & mdu.start & ~mdu.cancel;
  end

  // One iteration step: shift-add for multiply, restoring shift-subtract for divide.
  // Accumulator layout is {high/remainder, low/multiplier-or-quotient}.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, final_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift[XLEN-1:0] - a_q;
    div_ge    = div_shift >= {1'b0, a_q};
    if (op_q[2]) begin
      acc_step = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                        : {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
    prod = neg_res_q ? -acc_step : acc_step;
    quot = neg_res_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem  = neg_rem_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (op_q)
      3'd0:       final_res = prod[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:       final_res = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5: final_res = quot;
      default:    final_res = rem;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    regwe_lat_d = regwe_lat_q;
    a_d         = a_q;
    acc_d       = acc_q;
    neg_res_d   = neg_res_q;
    neg_rem_d   = neg_rem_q;
    result_d    = result_q;
    rd_o_d      = rd_o_q;
    valid_d     = 1'b0;
    regwe_o_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d        = mdu.op;
          regwe_lat_d = mdu.regwe;
          rd_o_d      = mdu.rd;
          a_d         = mag2;
          acc_d       = {{XLEN{1'b0}}, mag1};
          neg_res_d   = s1_neg ^ s2_neg;
          neg_rem_d   = s1_neg;
          if (early_out) begin
            state_d   = DONE;
            result_d  = early_res;
            valid_d   = 1'b1;
            regwe_o_d = mdu.regwe;
          end else begin
            state_d = CALC;
            cnt_d   = CNTW'(XLEN);
          end
        end
      end
      CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNTW'(1)) begin
          state_d   = DONE;
          result_d  = final_res;
          valid_d   = 1'b1;
          regwe_o_d = regwe_lat_q;
        end
      end
      default: begin
        // The stalled instruction is still in EX here, so start is not re-sampled.
        state_d = IDLE;
      end
    endcase
    if (mdu.cancel) begin
      state_d   = IDLE;
      valid_d   = 1'b0;
      regwe_o_d = 1'b0;
      result_d  = result_q;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      regwe_lat_q <= 1'b0;
      a_q         <= '0;
      acc_q       <= '0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      result_q    <= '0;
      rd_o_q      <= '0;
      regwe_o_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      regwe_lat_q <= regwe_lat_d;
      a_q         <= a_d;
      acc_q       <= acc_d;
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      result_q    <= result_d;
      rd_o_q      <= rd_o_d;
      regwe_o_q   <= regwe_o_d;
    end
  end

  assign mdu.stallreq = accept | (state_q == CALC);
  assign mdu.busy     = busy_q;
  assign mdu.valid    = valid_q;
  assign mdu.result   = result_q;
  assign mdu.rd_o     = rd_o_q;
  assign mdu.regwe_o  = regwe_o_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: the driver queues expected results, a negedge
// monitor pops and compares on every valid pulse.
module tb_ex_muldiv;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_muldiv_if #(.XLEN(XLEN)) mdu ();
  ex_muldiv #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .mdu(mdu));

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        regwe;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] last_res = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0 && mdu.valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 64'(mdu.valid), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("result", 64'(mdu.result), 64'(e.res));
        check("rd_o", 64'(mdu.rd_o), 64'(e.rd));
        check("regwe_o", 64'(mdu.regwe_o), 64'(e.regwe));
        $display("txn @%0t result=0x%08h rd=%0d regwe=%0b", $time, mdu.result, mdu.rd_o, mdu.regwe_o);
      end
    end
  end

  // Drive one op with start held until its valid cycle, as a stalled EX stage would.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] s1,
                        input logic [31:0] s2, input logic [4:0] rd, input logic regwe,
                        input logic [31:0] exp_res, input int lat);
    exp_t e;
    int   n;
    logic stall_bad;
    e = '{res: exp_res, rd: rd, regwe: regwe};
    sb_q.push_back(e);
    mdu.op = op; mdu.s1data = s1; mdu.s2data = s2; mdu.rd = rd; mdu.regwe = regwe;
    mdu.start = 1'b1;
    #1;
    check({name, "_stall_start"}, 64'(mdu.stallreq), 64'd1);
    @(posedge clk); #1;
    n = 1;
    stall_bad = 1'b0;
    while (mdu.valid !== 1'b1 && n < lat + 5) begin
      if (mdu.stallreq !== 1'b1) stall_bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(lat));
    check({name, "_stall_calc"}, 64'(stall_bad), 64'd0);
    check({name, "_stall_done"}, 64'(mdu.stallreq), 64'd0);
    last_res = exp_res;
    @(posedge clk); #1;
    mdu.start = 1'b0;
    check({name, "_single_valid"}, 64'(mdu.valid), 64'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1;
    mdu.start = 1'b0; mdu.cancel = 1'b0; mdu.op = '0;
    mdu.s1data = '0; mdu.s2data = '0; mdu.rd = '0; mdu.regwe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(mdu.busy), 64'd0);
    check("rst_valid", 64'(mdu.valid), 64'd0);
    check("rst_result", 64'(mdu.result), 64'd0);
    check("rst_rd_o", 64'(mdu.rd_o), 64'd0);
    check("rst_regwe_o", 64'(mdu.regwe_o), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd3,  1'b1, 32'hFFFF_FFEB, 33);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  1'b1, 32'hFFFF_FFFE, 33);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2,          5'd5,  1'b1, 32'hFFFF_FFFF, 33);
    run_op("mulh",   3'd1, 32'hFFFF_FFFD, 32'd5,          5'd6,  1'b1, 32'hFFFF_FFFF, 33);
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,          5'd7,  1'b1, 32'hFFFF_FFFD, 33);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,          5'd8,  1'b1, 32'hFFFF_FFFF, 33);
    run_op("divu",   3'd5, 32'd100,        32'd7,          5'd9,  1'b1, 32'h0000_000E, 33);
    run_op("remu",   3'd7, 32'd100,        32'd7,          5'd0,  1'b0, 32'h0000_0002, 33);
    run_op("divu0",  3'd5, 32'h0000_1234, 32'd0,          5'd10, 1'b1, 32'hFFFF_FFFF, 1);
    run_op("rem0",   3'd6, 32'h0000_0055, 32'd0,          5'd11, 1'b1, 32'h0000_0055, 1);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1, 32'h0000_0000, 1);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1, 32'h8000_0000, 1);

    // Flush a DIV at T+10; the unit must be idle at T+11 with no result written.
    mdu.op = 3'd4; mdu.s1data = 32'd1000; mdu.s2data = 32'd7; mdu.rd = 5'd14; mdu.regwe = 1'b1;
    mdu.start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
    end
    mdu.cancel = 1'b1; mdu.start = 1'b0;
    @(posedge clk); #1;
    mdu.cancel = 1'b0;
    check("cancel_busy", 64'(mdu.busy), 64'd0);
    check("cancel_valid", 64'(mdu.valid), 64'd0);
    check("cancel_regwe_o", 64'(mdu.regwe_o), 64'd0);
    check("cancel_stall", 64'(mdu.stallreq), 64'd0);
    check("cancel_result_kept", 64'(mdu.result), 64'(last_res));
    @(posedge clk); #1;
    run_op("mul_after_cancel", 3'd0, 32'd3, 32'd5, 5'd15, 1'b1, 32'h0000_000F, 33);

    // start together with cancel in IDLE is not accepted
    mdu.op = 3'd0; mdu.s1data = 32'd9; mdu.s2data = 32'd9;
    mdu.start = 1'b1; mdu.cancel = 1'b1;
    #1;
    check("start_cancel_stall", 64'(mdu.stallreq), 64'd0);
    @(posedge clk); #1;
    mdu.start = 1'b0; mdu.cancel = 1'b0;
    check("start_cancel_busy", 64'(mdu.busy), 64'd0);

    // Reset in the middle of an iteration
    mdu.op = 3'd0; mdu.s1data = 32'h1234; mdu.s2data = 32'h10; mdu.rd = 5'd16; mdu.regwe = 1'b1;
    mdu.start = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", 64'(mdu.busy), 64'd1);
    mdu.start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 64'(mdu.busy), 64'd0);
    check("midrst_valid", 64'(mdu.valid), 64'd0);
    check("midrst_result", 64'(mdu.result), 64'd0);
    check("midrst_rd_o", 64'(mdu.rd_o), 64'd0);
    check("midrst_regwe_o", 64'(mdu.regwe_o), 64'd0);
    check("midrst_stall", 64'(mdu.stallreq), 64'd0);
    sb_q.delete();
    last_res = '0;

    repeat (40) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Iterative RV32M/RV64M multiply-divide unit that sits beside the single-cycle ALU in the execute stage. It accepts already-forwarded operands, holds the pipeline through stallreq while it iterates, and then presents one result with its rd/regwe for the EX/MEM register. It is generalised over operand width, with selectable signedness and early-out paths for divide special cases.

Parameters:
XLEN, 32, operand/result width (32 or 64)
CNTW, $clog2(XLEN+1), iteration counter width (derived; do not override)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  EX holds an M-extension op with forwarded operands valid
cancel  in  1  flush current op (branch/trap); synchronous
op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
s1data  in  XLEN  operand 1 (rs1, post-forwarding)
s2data  in  XLEN  operand 2 (rs2, post-forwarding)
rd  in  5  destination register
regwe  in  1  write enable of the op
stallreq  out  1  combinational; holds IF/ID/EX
busy  out  1  registered; state != IDLE
valid  out  1  registered; result/rd_o/regwe_o valid this cycle
result  out  XLEN  product/quotient/remainder
rd_o  out  5  latched rd
regwe_o  out  1  latched regwe, qualified by valid

Behaviour:
- States: IDLE, CALC, DONE. On reset: state IDLE, busy 0, valid 0, result 0, rd_o 0, regwe_o 0, counter 0.
- IDLE & start & !cancel: latch op, rd, regwe, operand magnitudes and result sign.
  - Signed ops negate negative operands. MULHSU treats s1 as signed and s2 as unsigned.
  - Normal case: go to CALC with counter = XLEN.
  - Early-out: DIV*/REM* with s2 == 0, or signed with s1 == MIN and s2 == -1, goes directly to DONE.
- CALC: one bit per cycle.
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - Counter decrements each cycle; at counter == 1 go to DONE.
- DONE: valid = 1 for exactly one cycle, regwe_o = latched regwe, then return to IDLE.
  - start is ignored in DONE: the stalled instruction is still in EX that cycle.
- Result selection:
  - MUL: low XLEN bits.
  - MULH/MULHSU/MULHU: high XLEN bits after sign fix. The 2*XLEN product is negated when the sign flag is set.
  - Quotient sign = s1 sign XOR s2 sign. Remainder sign = dividend sign.
- Divide special cases:
  - Divide by zero: DIV/DIVU result all-ones; REM/REMU result = s1data.
  - Signed overflow: DIV result MIN (1 followed by XLEN-1 zeros); REM result 0.
- Latency from start cycle T: normal ops valid at T+XLEN+1; early-out ops valid at T+1.
- stallreq = (IDLE & start & !cancel) | CALC. It is 0 in DONE so the pipeline advances on the valid cycle.
- cancel: in any state, next state is IDLE, valid 0, regwe_o 0, result unchanged. cancel with start in IDLE means nothing is accepted.
- rst overrides cancel and start. Reset mid-CALC aborts with no valid pulse.
- regwe = 0 ops still iterate and pulse valid, with regwe_o = 0.
- rd = 0 is passed through unchanged; the regfile handles x0.

Test Plan:
- MUL s1=7, s2=0xFFFFFFFD (XLEN=32) -> valid at T+33, result 0xFFFFFFEB; stallreq high T..T+32, low at T+33.
- MULHU s1=s2=0xFFFFFFFF -> result 0xFFFFFFFE. MULHSU s1=0xFFFFFFFF, s2=2 -> result 0xFFFFFFFF.
- DIV s1=0xFFFFFFF9 (-7), s2=2 -> result 0xFFFFFFFD. Same operands with REM -> 0xFFFFFFFF. DIVU 100/7 -> 0x0E; REMU -> 0x02.
- DIVU s1=0x1234, s2=0 -> valid at T+1, result 0xFFFFFFFF. REM s1=0x80000000, s2=0xFFFFFFFF -> valid at T+1, result 0. DIV with the same operands -> 0x80000000.
- cancel asserted at T+10 of a DIV -> IDLE at T+11, no valid pulse. A new MUL 3*5 started at T+12 -> result 0x0F at T+45.
- rst asserted mid-CALC -> all outputs 0 next cycle, stallreq 0. start held through DONE -> exactly one valid pulse, no re-issue.
